// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions used by the bit-serial transmitter and receiver.
package cpu_pkg;

  // Default register word width of the CPU datapath.
  localparam int WORD_WIDTH = 16;

  // Serializer control states: waiting for a word, or streaming one out.
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Width of a bit-index counter covering 0..width-1.
  // Never returns less than 1, so degenerate widths still give a legal vector.
  function automatic int ser_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter: takes a WIDTH-bit word over valid/ready and
// streams it out one bit per accepted transfer, flagging the final bit.
module bit_serializer
  import cpu_pkg::*;
#(
  parameter int WIDTH     = WORD_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int             CW       = ser_cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  ser_state_t       state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [WIDTH-1:0] shreg_shifted;
  logic             bit_xfer;
  logic             word_take;

  // Shift toward the output end with zero fill; the output end depends on bit order.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shreg_shifted = {1'b0, shreg_reg[WIDTH-1:1]};
      assign out_bit       = shreg_reg[0];
    end else begin : g_msb_first
      assign shreg_shifted = {shreg_reg[WIDTH-2:0], 1'b0};
      assign out_bit       = shreg_reg[WIDTH-1];
    end
  endgenerate

  // Outputs decoded straight from registered state so in_data never reaches them.
  assign out_valid = (state_reg == SER_SHIFT);
  assign busy      = (state_reg == SER_SHIFT);
  assign out_last  = (state_reg == SER_SHIFT) && (cnt_reg == LAST_CNT);

  // A word can be taken when empty, or in the same cycle the final bit leaves;
  // held low during reset so nothing is accepted into a register being cleared.
  assign bit_xfer  = out_valid && out_ready;
  assign in_ready  = rst_n && ((state_reg == SER_IDLE) || (bit_xfer && out_last));
  assign word_take = in_valid && in_ready;

  // Next-state, shift-register and bit-counter update.
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;

    unique case (state_reg)
      SER_IDLE: begin
        if (word_take) begin
          shreg_next = in_data;
          cnt_next   = '0;
          state_next = SER_SHIFT;
        end
      end

      SER_SHIFT: begin
        if (bit_xfer) begin
          if (out_last) begin
            // Final bit leaves: reload back-to-back or fall empty.
            cnt_next = '0;
            if (word_take) begin
              shreg_next = in_data;
              state_next = SER_SHIFT;
            end else begin
              shreg_next = '0;
              state_next = SER_IDLE;
            end
          end else begin
            shreg_next = shreg_shifted;
            cnt_next   = cnt_reg + CW'(1);
          end
        end
        // Without a transfer everything holds, so a stalled bit is neither lost nor repeated.
      end

      default: begin
        state_next = SER_IDLE;
        shreg_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // State registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SER_IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench: an LSB-first and an MSB-first serializer share
// all inputs, and each transmitted bit is compared with hand-computed sequences.
module tb_bit_serializer;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic in_ready_l, out_bit_l, out_valid_l, out_last_l, busy_l;
  logic in_ready_m, out_bit_m, out_valid_m, out_last_m, busy_m;

  int n_total;
  int n_bad;
  int xfer_cnt;

  bit_serializer #(.WIDTH(16), .LSB_FIRST(1'b1)) u_lsb (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready_l),
    .out_bit  (out_bit_l),
    .out_valid(out_valid_l),
    .out_ready(out_ready),
    .out_last (out_last_l),
    .busy     (busy_l)
  );

  bit_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) u_msb (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready_m),
    .out_bit  (out_bit_m),
    .out_valid(out_valid_m),
    .out_ready(out_ready),
    .out_last (out_last_m),
    .busy     (busy_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count accepted serial transfers on the LSB-first instance.
  always @(posedge clk) begin
    if (rst_n && out_valid_l && out_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check one presented bit on both instances; k is the bit index in send order.
  task automatic chk_bit(input string name, input int k, input logic [15:0] seq_l,
                         input logic [15:0] seq_m);
    chk($sformatf("%s b%0d valid_l", name, k), 32'(out_valid_l), 32'd1);
    chk($sformatf("%s b%0d valid_m", name, k), 32'(out_valid_m), 32'd1);
    chk($sformatf("%s b%0d bit_l", name, k), 32'(out_bit_l), 32'(seq_l[k]));
    chk($sformatf("%s b%0d bit_m", name, k), 32'(out_bit_m), 32'(seq_m[k]));
    chk($sformatf("%s b%0d last_l", name, k), 32'(out_last_l), 32'(k == 15));
    chk($sformatf("%s b%0d last_m", name, k), 32'(out_last_m), 32'(k == 15));
    chk($sformatf("%s b%0d busy", name, k), 32'(busy_l), 32'd1);
  endtask

  // Send one word; seq_l/seq_m give the expected bit stream (bit k = k-th bit sent).
  // Optionally stall out_ready for stall_len cycles while bit stall_at is presented.
  task automatic run_word(input string name, input logic [15:0] d, input logic [15:0] seq_l,
                          input logic [15:0] seq_m, input int stall_at, input int stall_len);
    int x0;
    x0 = xfer_cnt;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({name, " idle in_ready"}, 32'(in_ready_l), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'h0;
    for (int k = 0; k < 16; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          chk_bit({name, " stall"}, k, seq_l, seq_m);
          chk($sformatf("%s stall%0d in_ready", name, s), 32'(in_ready_l), 32'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      #1;
      chk_bit(name, k, seq_l, seq_m);
      chk($sformatf("%s b%0d in_ready", name, k), 32'(in_ready_l), 32'(k == 15));
      @(posedge clk); #1;
    end
    chk({name, " end valid"}, 32'(out_valid_l), 32'd0);
    chk({name, " end busy"}, 32'(busy_m), 32'd0);
    chk({name, " end in_ready"}, 32'(in_ready_l), 32'd1);
    chk({name, " xfers"}, 32'(xfer_cnt - x0), 32'd16);
    $display("word %s data=%h done", name, d);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    xfer_cnt  = 0;
    rst_n     = 1'b0;
    in_data   = 16'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    #2;
    chk("rst in_ready", 32'(in_ready_l), 32'd0);
    chk("rst out_valid", 32'(out_valid_l), 32'd0);
    chk("rst out_bit", 32'(out_bit_l), 32'd0);
    chk("rst out_last", 32'(out_last_m), 32'd0);
    chk("rst busy", 32'(busy_l), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post-rst in_ready", 32'(in_ready_m), 32'd1);
    $display("reset checked");

    // Single word: A5C3 LSB-first is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; MSB-first reversed.
    run_word("single", 16'hA5C3, 16'hA5C3, 16'hC3A5, -1, 0);
    // 8001: both ends 1, zeros in between, in either order.
    run_word("msb8001", 16'h8001, 16'h8001, 16'h8001, -1, 0);
    // Backpressure on bit 5 for 3 cycles.
    run_word("stall5", 16'hFFFF, 16'hFFFF, 16'hFFFF, 5, 3);
    // Backpressure on the final bit: out_last must hold through the stall.
    run_word("stall15", 16'h8001, 16'h8001, 16'h8001, 15, 2);

    // Back-to-back: 0001 then 8000 with in_valid held; 8000 is offered (ignored)
    // for the whole of the first word and taken only on its last transfer.
    in_data   = 16'h0001;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = 16'h8000;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk_bit("b2b w0", k, 16'h0001, 16'h8000);
      chk($sformatf("b2b w0 b%0d in_ready", k), 32'(in_ready_l), 32'(k == 15));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 16'h0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk_bit("b2b w1", k, 16'h8000, 16'h0001);
      chk($sformatf("b2b w1 b%0d in_ready", k), 32'(in_ready_m), 32'(k == 15));
      @(posedge clk); #1;
    end
    chk("b2b end valid", 32'(out_valid_l), 32'd0);
    $display("back-to-back done");

    // Reset mid-word after 7 transfers of 1234.
    in_data   = 16'h1234;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid bit7", 32'(out_bit_l), 32'd0);
    chk("mid busy", 32'(busy_l), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid_l", 32'(out_valid_l), 32'd0);
    chk("mid rst valid_m", 32'(out_valid_m), 32'd0);
    chk("mid rst last", 32'(out_last_l), 32'd0);
    chk("mid rst busy", 32'(busy_m), 32'd0);
    chk("mid rst in_ready", 32'(in_ready_l), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("mid rel in_ready", 32'(in_ready_l), 32'd1);
    chk("mid rel valid", 32'(out_valid_l), 32'd0);
    $display("mid-word reset done");
    // 1234 reversed is 2C48.
    run_word("after-rst", 16'h1234, 16'h1234, 16'h2C48, -1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Guard against a run that never finishes.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial transmitter that sends a register word one bit per cycle to a serial bit sink, such as a 1-bit register chain or a shift-in receiver. It accepts a WIDTH-bit word over a valid/ready handshake and streams it out with its own valid/ready handshake. It raises a last-bit marker on the final bit. It sits between the CPU's word-wide registers and any bit-serial consumer in the datapath.

## Interface
Parameters:
- WIDTH, 16, word width in bits; legal range WIDTH >= 2.
- LSB_FIRST, 1, 1 sends bit 0 first; 0 sends bit WIDTH-1 first.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- in_data  input  WIDTH  parallel word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  serializer can accept a word this cycle.
- out_bit  output  1  current serial bit.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  sink accepts out_bit this cycle.
- out_last  output  1  out_bit is the final bit of the word; qualified by out_valid.
- busy  output  1  a word is in flight (state SHIFT).

## Operation
- FSM states: IDLE and SHIFT.
  - IDLE: the shift register is empty. in_valid && in_ready captures in_data into the shift register, clears the bit counter and moves to SHIFT.
  - SHIFT: out_valid = 1.
- Bit transfer: a bit transfers on out_valid && out_ready.
  - On a transfer, the shift register shifts toward the output end and the counter increments.
  - Shift direction: right when LSB_FIRST = 1, left when LSB_FIRST = 0.
  - Vacated bits fill with 0.
- out_bit: equals shreg[0] when LSB_FIRST = 1, and shreg[WIDTH-1] otherwise.
- out_last: equals 1 when counter == WIDTH-1 in SHIFT.
- End of word: a transfer with out_last set ends the word.
  - If in_valid is also high that cycle, the new word is captured and the FSM stays in SHIFT (back-to-back).
  - Otherwise the FSM returns to IDLE.
- in_ready = rst_n && (state == IDLE || (out_valid && out_ready && out_last)). It is combinational and has no dependency on in_valid.
- Stall: while out_ready = 0, out_bit, out_last and the counter hold. The bit is never dropped or repeated.
- Counter: width $clog2(WIDTH). It never wraps past WIDTH-1; on the last transfer it resets to 0.
- in_valid in SHIFT when not on the last transfer is ignored. The upstream source must hold in_valid and in_data until in_ready.
- Reset mid-word: the in-flight word is discarded, with no partial completion and no out_last.

## Timing
- Reset values: state IDLE, shreg 0, counter 0, out_bit 0, out_valid 0, out_last 0, busy 0. in_ready is 0 while rst_n is low and 1 from the first cycle after release.
- Latency: a word accepted at edge N presents its first bit valid after edge N; that bit is transferable in cycle N+1.
- Throughput with out_ready held at 1:
  - one bit per cycle.
  - WIDTH cycles per word back-to-back, with no idle bubble.
  - WIDTH+1 cycles per word if in_valid arrives one cycle late.
- out_bit, out_valid, out_last and busy are registered or decoded directly from state and shreg. There is no combinational path from in_data.
- Combinational paths: out_ready reaches in_ready combinationally. No other input-to-output combinational paths exist.

## Structure
- Shared package cpu_pkg holds:
  - WORD_WIDTH = 16, the default for WIDTH.
  - the state enum ser_state_t {SER_IDLE, SER_SHIFT}.
  - the helper constant for counter width.
- No sub-module is needed. Shift register, counter and FSM live in one module of roughly 120-180 lines.
- The matching bit_deserializer receiver reuses cpu_pkg.

## Test plan
- Reset then single word: in_data = 16'hA5C3, LSB_FIRST = 1, out_ready = 1 -> bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles; out_last only on the 16th; then IDLE, in_ready = 1.
- MSB-first: LSB_FIRST = 0, in_data = 16'h8001 -> first bit 1, 14 zeros, last bit 1 with out_last.
- Backpressure: out_ready low for 3 cycles on bit 5 of 16'hFFFF -> out_bit, counter and out_valid hold; exactly 16 transfers in total.
- Back-to-back: in_valid held high with words 16'h0001 then 16'h8000 -> 32 consecutive valid bits, no gap; in_ready pulses high exactly on each last-bit transfer.
- Reset mid-word: assert rst_n low after 7 transfers -> out_valid is 0 immediately (async); after release, state IDLE and in_ready = 1; next word transmits cleanly from bit 0.
- in_valid during SHIFT not on the last bit -> ignored; the word in flight is unchanged.
